// File: rtl/get_cert_request_sequencer.sv
// Issues the GET_CERTIFICATE request stream for one slot, chunking each certificate and tracking the chain offset.
// Optional: define GET_CERT_RETRY_EN to retry nacked requests up to MAX_RETRY times.
module get_cert_request_sequencer #(
  parameter int NUM_SLOTS = 4,
  parameter int MAX_CERTS = 8,
  parameter int LEN_W = 16,
  parameter int MAX_CHUNK = 256,
  parameter int HEADER_W = 32,
  parameter logic [HEADER_W-1:0] HEADER_BASE = '0,
  parameter int PAD_W = 2024,
  parameter int MAX_RETRY = 3,
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int IDX_W = (MAX_CERTS > 1) ? $clog2(MAX_CERTS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [SLOT_W-1:0]        cfg_slot,
  input  logic [IDX_W-1:0]         cfg_idx,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic                     cfg_cnt_we,
  input  logic [IDX_W:0]           cfg_cnt,
  input  logic                     start,
  input  logic [SLOT_W-1:0]        slot,
  input  logic                     abort,
  output logic                     msg_valid,
  input  logic                     msg_ready,
  output logic [HEADER_W-1:0]      header,
  output logic [2*LEN_W+PAD_W-1:0] payload,
  input  logic                     resp_ack,
  input  logic                     resp_nack,
  output logic [IDX_W:0]           expected_certificates,
  output logic [IDX_W-1:0]         cert_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);
  localparam logic [LEN_W:0] CHUNK   = MAX_CHUNK[LEN_W:0];
  localparam logic [LEN_W:0] MAX_OFF = {1'b0, {LEN_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DONE} state_t;
  state_t state;

  logic [LEN_W-1:0] len_tab [NUM_SLOTS][MAX_CERTS];
  logic [IDX_W:0]   cnt_tab [NUM_SLOTS];
  logic [SLOT_W-1:0] slot_q;
  logic [LEN_W-1:0] off_q, req_q, rem_q;

`ifdef GET_CERT_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_q;
`endif

  logic [IDX_W:0]   idx_inc;
  logic [IDX_W-1:0] nxt_idx;
  logic             more_certs, load_en, adv_cert, fin, l_ovf;
  logic [LEN_W-1:0] rem_after, off_after, l_rem, l_off, l_req;
  logic [LEN_W:0]   l_sum;

  assign header  = {HEADER_BASE[HEADER_W-1:SLOT_W], slot_q};
  assign payload = {off_q, req_q, {PAD_W{1'b0}}};

  // Selects the next (remaining, offset) pair to issue; a zero remaining means skip this cert.
  always_comb begin
    idx_inc    = {1'b0, cert_idx} + {{IDX_W{1'b0}}, 1'b1};
    nxt_idx    = idx_inc[IDX_W-1:0];
    more_certs = idx_inc < expected_certificates;
    rem_after  = rem_q - req_q;
    off_after  = off_q + req_q;
    load_en    = 1'b0;
    adv_cert   = 1'b0;
    fin        = 1'b0;
    l_rem      = '0;
    l_off      = '0;
    case (state)
      IDLE: if (start && cnt_tab[slot] != '0) begin
        load_en = 1'b1;
        l_rem   = len_tab[slot][0];
      end
      ISSUE: if (!msg_valid) begin
        if (more_certs) begin
          load_en  = 1'b1;
          adv_cert = 1'b1;
          l_rem    = len_tab[slot_q][nxt_idx];
          l_off    = off_q;
        end else fin = 1'b1;
      end
      WAIT_RESP: if (resp_ack) begin
        l_off = off_after;
        if (rem_after != '0) begin
          load_en = 1'b1;
          l_rem   = rem_after;
        end else if (more_certs) begin
          load_en  = 1'b1;
          adv_cert = 1'b1;
          l_rem    = len_tab[slot_q][nxt_idx];
        end else fin = 1'b1;
      end
      default: ;
    endcase
    l_req = ({1'b0, l_rem} > CHUNK) ? CHUNK[LEN_W-1:0] : l_rem;
    l_sum = {1'b0, l_off} + {1'b0, l_req};
    l_ovf = l_sum > MAX_OFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      msg_valid             <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      error                 <= 1'b0;
      slot_q                <= '0;
      off_q                 <= '0;
      req_q                 <= '0;
      rem_q                 <= '0;
      cert_idx              <= '0;
      expected_certificates <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        cnt_tab[s] <= '0;
        for (int i = 0; i < MAX_CERTS; i++) len_tab[s][i] <= '0;
      end
`ifdef GET_CERT_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (!busy && cfg_we)     len_tab[cfg_slot][cfg_idx] <= cfg_len;
      if (!busy && cfg_cnt_we) cnt_tab[cfg_slot] <= cfg_cnt;
      if (abort) begin
        state     <= IDLE;
        msg_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            slot_q                <= slot;
            expected_certificates <= cnt_tab[slot];
            cert_idx              <= '0;
            off_q                 <= '0;
            error                 <= 1'b0;
            busy                  <= 1'b1;
`ifdef GET_CERT_RETRY_EN
            retry_q <= '0;
`endif
            if (cnt_tab[slot] == '0) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
          end
          ISSUE: if (msg_valid && msg_ready) begin
            msg_valid <= 1'b0;
            state     <= WAIT_RESP;
          end
          WAIT_RESP: if (resp_ack) begin
`ifdef GET_CERT_RETRY_EN
            retry_q <= '0;
`endif
          end else if (resp_nack) begin
`ifdef GET_CERT_RETRY_EN
            if (retry_q == RW'(MAX_RETRY)) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              retry_q   <= retry_q + RW'(1);
              msg_valid <= 1'b1;
              state     <= ISSUE;
            end
`else
            error <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
`endif
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
        if (adv_cert) cert_idx <= nxt_idx;
        if (fin) begin
          done  <= 1'b1;
          state <= DONE;
        end
        if (load_en) begin
          if (l_rem == '0) begin
            state     <= ISSUE;
            msg_valid <= 1'b0;
            rem_q     <= '0;
            off_q     <= l_off;
          end else if (l_ovf) begin
            error     <= 1'b1;
            done      <= 1'b1;
            msg_valid <= 1'b0;
            state     <= DONE;
          end else begin
            state     <= ISSUE;
            msg_valid <= 1'b1;
            rem_q     <= l_rem;
            req_q     <= l_req;
            off_q     <= l_off;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_get_cert_request_sequencer.sv
// Bench for get_cert_request_sequencer: vector table of slot sequences checked against a chunking model via a scoreboard.
module tb_get_cert_request_sequencer;
  localparam int NUM_SLOTS = 4, MAX_CERTS = 8, LEN_W = 16, MAX_CHUNK = 256;
  localparam int HEADER_W = 32, PAD_W = 2024, MAX_RETRY = 3;
  localparam int SLOT_W = 2, IDX_W = 3, PW = 2*LEN_W + PAD_W;

  logic clk = 1'b0;
  logic reset;
  logic cfg_we, cfg_cnt_we, start, abort, msg_ready, resp_ack, resp_nack;
  logic [SLOT_W-1:0] cfg_slot, slot;
  logic [IDX_W-1:0] cfg_idx;
  logic [LEN_W-1:0] cfg_len;
  logic [IDX_W:0] cfg_cnt;
  logic msg_valid, busy, done, error;
  logic [HEADER_W-1:0] header;
  logic [PW-1:0] payload;
  logic [IDX_W:0] expected_certificates;
  logic [IDX_W-1:0] cert_idx;

  always #5 clk = ~clk;

  get_cert_request_sequencer #(
    .NUM_SLOTS(NUM_SLOTS), .MAX_CERTS(MAX_CERTS), .LEN_W(LEN_W), .MAX_CHUNK(MAX_CHUNK),
    .HEADER_W(HEADER_W), .HEADER_BASE('0), .PAD_W(PAD_W), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_idx(cfg_idx),
    .cfg_len(cfg_len), .cfg_cnt_we(cfg_cnt_we), .cfg_cnt(cfg_cnt), .start(start), .slot(slot),
    .abort(abort), .msg_valid(msg_valid), .msg_ready(msg_ready), .header(header),
    .payload(payload), .resp_ack(resp_ack), .resp_nack(resp_nack),
    .expected_certificates(expected_certificates), .cert_idx(cert_idx), .busy(busy),
    .done(done), .error(error)
  );

  typedef struct { int off; int len; int idx; } exp_t;
  typedef struct { int slot; int cnt; int len0; int len1; int stall; int nacks; int exp_msgs; int exp_err; } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference chunking: MAX_CHUNK-sized reads, zero-length certs skipped, stop before offset wraps.
  task automatic model(input int cnt, input int l0, input int l1, output int ovf);
    int off, rem, req;
    off = 0;
    ovf = 0;
    for (int i = 0; i < cnt && ovf == 0; i++) begin
      rem = (i == 0) ? l0 : l1;
      while (rem > 0 && ovf == 0) begin
        req = (rem > MAX_CHUNK) ? MAX_CHUNK : rem;
        if (off + req > 65535) ovf = 1;
        else begin
          sb.push_back('{off, req, i});
          off += req;
          rem -= req;
        end
      end
    end
  endtask

  task automatic wr(input int s, input int cnt, input int l0, input int l1);
    cfg_slot = s[SLOT_W-1:0];
    cfg_cnt_we = 1'b1; cfg_cnt = cnt[IDX_W:0];
    @(negedge clk);
    cfg_cnt_we = 1'b0;
    cfg_we = 1'b1; cfg_idx = 0; cfg_len = l0[LEN_W-1:0];
    @(negedge clk);
    cfg_idx = 1; cfg_len = l1[LEN_W-1:0];
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int hs, dones, err_d, nk, stall_left, pending, stalled, ovf, cyc;
    logic [PW-1:0] hold_p;
    logic [HEADER_W-1:0] hold_h;
    exp_t e, last;
    hs = 0; dones = 0; err_d = 0; nk = 0; pending = 0; stalled = 0;
    last = '{0, 0, 0};
    sb.delete();
    model(v.cnt, v.len0, v.len1, ovf);
    stall_left = v.stall;
    slot = v.slot[SLOT_W-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d expected_certificates", id), expected_certificates, v.cnt);
    if (v.len0 != 0) check($sformatf("v%0d first_valid_latency", id), msg_valid, 1);
    for (cyc = 0; cyc < 2000; cyc++) begin
      resp_ack = 1'b0; resp_nack = 1'b0; msg_ready = 1'b0;
      if (done) begin dones++; err_d = error; end
      if (!busy) break;
      if (pending != 0) begin
        pending = 0;
        if (nk < v.nacks) begin
          resp_nack = 1'b1;
`ifdef GET_CERT_RETRY_EN
          if (nk < MAX_RETRY) sb.push_front(last);
`endif
          nk++;
        end else resp_ack = 1'b1;
      end
      if (msg_valid) begin
        if (stall_left > 0) begin
          if (stalled == 0) begin hold_p = payload; hold_h = header; stalled = 1; end
          else begin
            check($sformatf("v%0d stall_payload_stable", id), payload == hold_p, 1);
            check($sformatf("v%0d stall_header_stable", id), header, hold_h);
          end
          stall_left--;
        end else begin
          if (stalled != 0) begin
            check($sformatf("v%0d stall_payload_stable", id), payload == hold_p, 1);
            stalled = 0;
          end
          msg_ready = 1'b1;
          hs++;
          pending = 1;
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL v%0d unexpected_msg: got offset %0d len %0d, expected no message", id,
                     payload[PW-1 -: LEN_W], payload[PW-LEN_W-1 -: LEN_W]);
          end else begin
            e = sb.pop_front();
            last = e;
            check($sformatf("v%0d msg%0d offset", id, hs), payload[PW-1 -: LEN_W], e.off);
            check($sformatf("v%0d msg%0d req_len", id, hs), payload[PW-LEN_W-1 -: LEN_W], e.len);
            check($sformatf("v%0d msg%0d cert_idx", id, hs), cert_idx, e.idx);
            check($sformatf("v%0d msg%0d header", id, hs), header, v.slot);
            check($sformatf("v%0d msg%0d pad_zero", id, hs), payload[PAD_W-1:0] == '0, 1);
          end
        end
      end
      @(negedge clk);
    end
    resp_ack = 1'b0; resp_nack = 1'b0; msg_ready = 1'b0;
    if (cyc >= 2000) begin
      n_chk++; n_fail++;
      $display("FAIL v%0d timeout: still busy after %0d cycles, expected done", id, cyc);
    end
    check($sformatf("v%0d done_pulses", id), dones, 1);
    check($sformatf("v%0d error", id), err_d, v.exp_err);
    check($sformatf("v%0d handshakes", id), hs, v.exp_msgs);
    check($sformatf("v%0d scoreboard_left", id), sb.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    cfg_we = 0; cfg_cnt_we = 0; cfg_slot = 0; cfg_idx = 0; cfg_len = 0; cfg_cnt = 0;
    start = 0; slot = 0; abort = 0; msg_ready = 0; resp_ack = 0; resp_nack = 0;

    vecs.push_back('{1, 2, 300, 100, 0, 0, 3, 0});
    vecs.push_back('{2, 1, 200, 0, 5, 0, 1, 0});
    vecs.push_back('{3, 2, 0, 50, 0, 0, 1, 0});
`ifdef GET_CERT_RETRY_EN
    vecs.push_back('{0, 1, 10, 0, 0, 3, 4, 0});
    vecs.push_back('{0, 1, 10, 0, 0, 4, 4, 1});
`else
    vecs.push_back('{0, 1, 10, 0, 0, 1, 1, 1});
`endif
    vecs.push_back('{2, 2, 65000, 1000, 0, 0, 256, 1});

    repeat (3) @(negedge clk);
    check("reset msg_valid", msg_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    check("reset header", header, 0);
    check("reset payload_zero", payload == '0, 1);
    check("reset expected_certificates", expected_certificates, 0);
    check("reset cert_idx", cert_idx, 0);
    reset = 1'b0;
    @(negedge clk);

    // Tables come out of reset empty, so slot 0 has zero certificates.
    slot = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cnt0 done_at_n1", done, 1);
    check("cnt0 error", error, 1);
    check("cnt0 msg_valid", msg_valid, 0);
    @(negedge clk);
    check("cnt0 done_one_cycle", done, 0);
    check("cnt0 busy_cleared", busy, 0);

    foreach (vecs[i]) begin
      wr(vecs[i].slot, vecs[i].cnt, vecs[i].len0, vecs[i].len1);
      run_vec(vecs[i], i);
      @(negedge clk);
    end

    // Abort while waiting for the response to the second message.
    wr(1, 2, 300, 100);
    slot = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; msg_ready = 1'b1;
    @(negedge clk);
    msg_ready = 1'b0; resp_ack = 1'b1;
    @(negedge clk);
    resp_ack = 1'b0;
    check("abort second_msg_valid", msg_valid, 1);
    check("abort second_offset", payload[PW-1 -: LEN_W], 256);
    msg_ready = 1'b1;
    @(negedge clk);
    msg_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort msg_valid", msg_valid, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort error_unchanged", error, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort no_late_done", done, 0);
    end
    run_vec(vecs[0], 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/get_cert_request_sequencer.md
# get_cert_request_sequencer

- Generates the full sequence of GET_CERTIFICATE request messages for one certificate slot.
- Splits each certificate into chunk-sized reads and tracks the running chain offset.
- Issues each request over a valid/ready handshake and waits for the response before the next one.
- Sits between the certificate-control FSM and the message transmitter; runtime-loadable per-slot length tables replace hard-coded slot constants.

## Interface
Parameters:
- NUM_SLOTS, 4 — certificate slots supported; SLOT_W = $clog2(NUM_SLOTS)
- MAX_CERTS, 8 — certificates per slot; IDX_W = $clog2(MAX_CERTS)
- LEN_W, 16 — width of offset and length fields
- MAX_CHUNK, 256 — maximum bytes requested per message; must be ≥1
- HEADER_W, 32 — header width
- HEADER_BASE, 32'h0 — header template; the low SLOT_W bits are replaced by the slot number
- PAD_W, 2024 — zero padding appended to the payload
- MAX_RETRY, 3 — retries per request (only with the retry macro)

Ports:
- clk  in  1  — clock
- reset  in  1  — synchronous, active-high
- cfg_we  in  1  — write certificate length
- cfg_slot  in  SLOT_W  — table write slot
- cfg_idx  in  IDX_W  — table write certificate index
- cfg_len  in  LEN_W  — certificate length in bytes
- cfg_cnt_we  in  1  — write certificate count of cfg_slot
- cfg_cnt  in  IDX_W+1  — number of certificates, 0..MAX_CERTS
- start  in  1  — begin sequence (pulse)
- slot  in  SLOT_W  — slot to read; sampled with start
- abort  in  1  — cancel sequence
- msg_valid  out  1  — request message available
- msg_ready  in  1  — transmitter accepts message
- header  out  HEADER_W  — {HEADER_BASE[HEADER_W-1:SLOT_W], slot}
- payload  out  2*LEN_W+PAD_W  — {offset, req_len, PAD_W'h0}
- resp_ack  in  1  — response received OK
- resp_nack  in  1  — response failed/timed out
- expected_certificates  out  IDX_W+1  — count of the active slot
- cert_idx  out  IDX_W  — certificate being read
- busy  out  1  — high in any state except IDLE
- done  out  1  — one-cycle pulse, sequence complete
- error  out  1  — sticky; cleared on the next accepted start

## Operation
- States: IDLE, ISSUE, WAIT_RESP, DONE.
- **IDLE**
  - start latches slot, clears offset, cert_idx and error, and loads remaining = len[slot][0].
  - If the slot count is 0: go to DONE with error=1.
  - Otherwise: go to ISSUE.
- **ISSUE**
  - msg_valid=1 with req_len = min(remaining, MAX_CHUNK).
  - header and payload are held stable while msg_valid && !msg_ready.
  - msg_valid && msg_ready: go to WAIT_RESP.
- **WAIT_RESP on resp_ack**
  - offset += req_len and remaining -= req_len.
  - If remaining ≠ 0: go to ISSUE.
  - Else, if cert_idx+1 < count: cert_idx++, reload remaining, go to ISSUE.
  - Else: go to DONE.
- **Zero-length certificate**: skipped with no message issued; offset is unchanged.
- **Offset overflow**: if offset+req_len exceeds 2^LEN_W−1, set error, suppress the message, go to DONE.
- **DONE**: done=1 for one cycle, then go to IDLE.
- **Simultaneous resp_ack and resp_nack**: resp_ack wins.
- **abort**: in any state, go to IDLE next cycle; msg_valid drops, no done, error unchanged. abort wins over start and responses.
- **Table writes**: cfg_we and cfg_cnt_we are ignored while busy. Tables reset to zero.

## Timing
- Reset values:
  - All outputs 0; header = {HEADER_BASE upper bits, 0}.
  - Tables, offset and retry counter are 0; state is IDLE.
- Latency:
  - start at cycle N gives msg_valid at N+1.
  - resp_ack at cycle M gives the next msg_valid at M+1.
  - done asserts the cycle after the final resp_ack.
- Handshake rules:
  - A response arriving while not in WAIT_RESP is ignored.
  - start while busy is ignored.
- expected_certificates is valid from N+1 and holds until the next start.

## Configuration
- Macro: GET_CERT_RETRY_EN.
- Defined:
  - resp_nack re-enters ISSUE with the same offset and req_len and increments the retry counter.
  - On the (MAX_RETRY+1)-th nack, set error and go to DONE.
  - The retry counter clears on each resp_ack.
- Undefined: any resp_nack sets error and goes to DONE. The MAX_RETRY parameter is unused.

## Test plan
- Slot 1 loaded with counts 2 and lengths {300, 100}; start with msg_ready=1 and immediate acks → payload (offset, len) sequence (0,256), (256,44), (300,100); done pulses once; error=0.
- msg_ready held low 5 cycles during the first request → header and payload stable for all 5 cycles; exactly one handshake.
- Slot with count 0 → done at N+1, error=1, no msg_valid.
- abort asserted in WAIT_RESP of the second message → msg_valid low next cycle, busy=0, no done; a new start restarts at offset 0.
- Retry:
  - With GET_CERT_RETRY_EN and MAX_RETRY=3: 3 nacks then ack → request repeated 4 times with identical payload; sequence completes; error=0.
  - 4 nacks → error=1 and done.
  - Without the macro: 1 nack → error=1 and done.
- Certificate lengths {65000, 1000} → overflow on the second certificate: error=1, done, no message issued with wrapped offset.
